// File: rtl/fft_pkg.sv
// Shared widths, FSM encodings, complex word type and index helpers for fft_seq.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 10;

  localparam logic [4:0] ST_LOAD  = 5'b00001;
  localparam logic [4:0] ST_START = 5'b00010;
  localparam logic [4:0] ST_RUN   = 5'b00100;
  localparam logic [4:0] ST_ACK   = 5'b01000;
  localparam logic [4:0] ST_DRAIN = 5'b10000;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  // Reverse the low m bits of n; bits above m come back zero.
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] n, input int unsigned m);
    logic [IDX_W-1:0] rev;
    rev = {<<{n}};
    return rev >> (IDX_W - m);
  endfunction

  function automatic logic [DATA_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    return {{(DATA_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/fft_seq_ram.sv
// N-entry complex sample RAM: two synchronous write ports, combinational read ports
// for the engine operands plus one for the result stream. Contents are never reset.
module fft_seq_ram
  import fft_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_waddr_a,
  input  cplx_t         i_wdata_a,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_waddr_b,
  input  cplx_t         i_wdata_b,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  input  logic [AW-1:0] i_raddr_c,
  output cplx_t         o_rdata_a,
  output cplx_t         o_rdata_b,
  output cplx_t         o_rdata_c
);

  cplx_t r_mem [N];

  // Port A is written last so it wins on an address collision.
  always_ff @(posedge Clk) begin
    if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
    if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_c = r_mem[i_raddr_c];

endmodule

// File: rtl/fft_seq.sv
// fft_seq: loads one N-point frame, hands the RAM to an external FFT1024 butterfly engine,
// then streams the bins out. Define FFT_SEQ_SCALE_EN to halve every butterfly write-back.
//
// state | meaning
// LOAD  | accept N samples, store at bit-reversed addresses
// START | one-cycle start pulse to the engine
// RUN   | engine drives indices; butterflies written back while Proc
// ACK   | one-cycle ack pulse after Done
// DRAIN | present mem[r] with out_valid, advance r per handshake
module fft_seq
  import fft_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [SAMPLE_W-1:0] in_re,
  input  logic signed [SAMPLE_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [IDX_W-1:0]         out_index,
  output logic                     fft_start,
  output logic                     fft_ack,
  input  logic [3:0]               fft_state,
  input  logic [IDX_W-1:0]         fft_i_top,
  input  logic [IDX_W-1:0]         fft_i_bot,
  output logic signed [DATA_W-1:0] fft_x_top_re,
  output logic signed [DATA_W-1:0] fft_x_top_im,
  output logic signed [DATA_W-1:0] fft_x_bot_re,
  output logic signed [DATA_W-1:0] fft_x_bot_im,
  input  logic signed [DATA_W-1:0] fft_y_top_re,
  input  logic signed [DATA_W-1:0] fft_y_top_im,
  input  logic signed [DATA_W-1:0] fft_y_bot_re,
  input  logic signed [DATA_W-1:0] fft_y_bot_im,
  output logic                     busy
);

  localparam logic [M-1:0] LAST_IDX = M'(N - 1);

  logic [4:0]       r_state;
  logic [4:0]       w_state_nxt;
  logic [M-1:0]     r_wr_cnt;
  logic [M-1:0]     r_rd_idx;
  logic             w_in_load;
  logic             w_in_run;
  logic             w_in_drain;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_proc_wr;
  logic [IDX_W-1:0] w_load_idx;
  logic [M-1:0]     w_waddr_a;
  cplx_t            w_wdata_a;
  cplx_t            w_wdata_b;
  cplx_t            w_rd_top;
  cplx_t            w_rd_bot;
  cplx_t            w_rd_out;
  logic             w_unused;

  function automatic logic [DATA_W-1:0] wb_scale(input logic [DATA_W-1:0] y);
`ifdef FFT_SEQ_SCALE_EN
    return $signed(y) >>> 1;
`else
    return y;
`endif
  endfunction

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_in_run   = (r_state == ST_RUN);
  assign w_in_drain = (r_state == ST_DRAIN);
  assign w_in_hs    = w_in_load & in_valid;
  assign w_out_hs   = w_in_drain & out_ready;
  // Proc and Done are one-hot from the engine; Done always suppresses the write.
  assign w_proc_wr  = w_in_run & fft_state[1] & ~fft_state[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:  if (w_in_hs && r_wr_cnt == LAST_IDX) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   if (fft_state[0]) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_hs && r_rd_idx == LAST_IDX) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_LOAD;
      r_wr_cnt <= '0;
      r_rd_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_hs) r_wr_cnt <= (r_wr_cnt == LAST_IDX) ? '0 : r_wr_cnt + M'(1);
      if (w_out_hs) r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + M'(1);
    end
  end

  assign w_load_idx = bitrev(IDX_W'(r_wr_cnt), M);
  assign w_waddr_a  = w_in_load ? w_load_idx[M-1:0] : fft_i_top[M-1:0];

  always_comb begin
    w_wdata_a.re = wb_scale(fft_y_top_re);
    w_wdata_a.im = wb_scale(fft_y_top_im);
    w_wdata_b.re = wb_scale(fft_y_bot_re);
    w_wdata_b.im = wb_scale(fft_y_bot_im);
    if (w_in_load) begin
      w_wdata_a.re = sext(in_re);
      w_wdata_a.im = sext(in_im);
    end
  end

  fft_seq_ram #(.N(N), .AW(M)) u_ram (
    .Clk       (Clk),
    .i_we_a    (w_in_hs | w_proc_wr),
    .i_waddr_a (w_waddr_a),
    .i_wdata_a (w_wdata_a),
    .i_we_b    (w_proc_wr),
    .i_waddr_b (fft_i_bot[M-1:0]),
    .i_wdata_b (w_wdata_b),
    .i_raddr_a (fft_i_top[M-1:0]),
    .i_raddr_b (fft_i_bot[M-1:0]),
    .i_raddr_c (r_rd_idx),
    .o_rdata_a (w_rd_top),
    .o_rdata_b (w_rd_bot),
    .o_rdata_c (w_rd_out)
  );

  assign in_ready     = w_in_load;
  assign busy         = ~w_in_load;
  assign fft_start    = (r_state == ST_START);
  assign fft_ack      = (r_state == ST_ACK);
  assign out_valid    = w_in_drain;
  assign out_re       = w_rd_out.re;
  assign out_im       = w_rd_out.im;
  assign out_index    = IDX_W'(r_rd_idx);
  assign fft_x_top_re = w_rd_top.re;
  assign fft_x_top_im = w_rd_top.im;
  assign fft_x_bot_re = w_rd_bot.re;
  assign fft_x_bot_im = w_rd_bot.im;

  // Engine index bits above the frame size and Init/Load flags carry no meaning here.
  assign w_unused = ^{fft_state[3:2], fft_i_top[IDX_W-1:M], fft_i_bot[IDX_W-1:M],
                      w_load_idx[IDX_W-1:M]};

endmodule
